// File: rtl/sha256_compress_engine.sv
// SHA-256 compression core: one 512-bit block in, 64 rounds at ROUNDS_PER_CYCLE per clock,
// digest out with valid/ready; later blocks chain from the held digest when in_first=0.
module sha256_compress_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;

  // word 0 is the most significant: a..h / H0..H7 line up with the 256-bit digest layout
  typedef logic [0:7][31:0] hv_t;

  localparam hv_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic hv_t round_f(input hv_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
       + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
       + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

  function automatic hv_t add8(input hv_t x, input hv_t y);
    hv_t z;
    for (int i = 0; i < 8; i++) z[i] = x[i] + y[i];
    return z;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [6:0]             cnt;
  logic [0:15][31:0]      win;
  hv_t                    ah, base, dig;
  logic [0:R+15][31:0]    ext;
  hv_t                    st [R+1];

  // win holds W[cnt..cnt+15]; ext appends the R words needed to slide it R places
  always_comb begin
    ext = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int r = 0; r < R; r++)
      ext[16+r] = ss1(ext[14+r]) + ext[9+r] + ss0(ext[1+r]) + ext[r];
    st[0] = ah;
    for (int r = 0; r < R; r++)
      st[r+1] = round_f(st[r], K[cnt[5:0] + 6'(r)], ext[r]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      win       <= '0;
      ah        <= '0;
      base      <= '0;
      dig       <= IV;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          win      <= in_block;
          ah       <= in_first ? IV : dig;
          base     <= in_first ? IV : dig;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          ah  <= st[R];
          cnt <= cnt + 7'(R);
          for (int i = 0; i < 16; i++) win[i] <= ext[i+R];
          if (cnt == 7'(64 - R)) begin
            dig       <= add8(base, st[R]);
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_digest = dig;
endmodule

// File: tb/tb_sha256_compress_engine.sv
// Bench for sha256_compress_engine: four instances (R=1,2,4,8) checked against known digests
// and a plain full-schedule SHA-256 compression model, plus handshake and reset corner cases.
module tb_sha256_compress_engine;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [511:0] in_block = '0;
  logic         in_first = 1'b0;
  logic [3:0]   in_valid = '0, out_ready = '0;
  logic [3:0]   in_ready, out_valid, busy;
  logic [255:0] out_digest [4];

  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_block(in_block), .in_first(in_first),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_digest(out_digest[g]), .busy(busy[g]));
  end

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // straightforward textbook compression: full 64-word schedule, then 64 rounds
  function automatic logic [255:0] model(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one block on instance d, count edges to out_valid, then handshake it away
  task automatic send(input int d, input logic [511:0] blk, input logic first,
                      output logic [255:0] dig, output int lat);
    int n;
    @(negedge clk);
    in_block = blk; in_first = first; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    dig = out_digest[d];
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic [255:0] exp;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    logic [255:0] chain [4];
    logic [255:0] dig, held;
    logic [511:0] blk;
    logic first;
    int lat;

    tbl[0] = '{ABC, 1'b1, D_ABC};
    tbl[1] = '{EMPTY, 1'b1, D_EMPTY};
    tbl[2] = '{TWO1, 1'b1, model(IV, TWO1)};
    tbl[3] = '{TWO2, 1'b0, D_TWO};

    #12;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_digest[%0d]", d), out_digest[d], IV);
      chk($sformatf("reset_flags[%0d]", d), {in_ready[d], out_valid[d], busy[d]}, 3'b100);
    end
    @(negedge clk); reset_n = 1'b1;

    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 4; v++) begin
        send(d, tbl[v].blk, tbl[v].first, dig, lat);
        chk($sformatf("vec%0d_digest[R=%0d]", v, 1 << d), dig, tbl[v].exp);
        chk($sformatf("vec%0d_latency[R=%0d]", v, 1 << d), lat, 64 >> d);
      end
      chain[d] = D_TWO;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom();
        first = ($urandom_range(0, 1) == 1);
        chain[d] = model(first ? IV : chain[d], blk);
        send(d, blk, first, dig, lat);
        chk($sformatf("rand%0d_digest[R=%0d]", k, 1 << d), dig, chain[d]);
        chk($sformatf("rand%0d_latency[R=%0d]", k, 1 << d), lat, 64 >> d);
      end
    end

    // back-pressure in DONE while in_valid stays high with a different block
    @(negedge clk);
    in_block = ABC; in_first = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) in_block[511-32*i -: 32] = $urandom();
    in_first = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 64);
    chk("bp_digest", out_digest[0], D_ABC);
    held = out_digest[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_flags%0d", c), {out_valid[0], in_ready[0], busy[0]}, 3'b101);
      chk($sformatf("bp_hold_digest%0d", c), out_digest[0], D_ABC);
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("after_hs_flags", {out_valid[0], in_ready[0], busy[0]}, 3'b010);
    chk("after_hs_digest", out_digest[0], held);
    repeat (3) @(posedge clk); #1;
    chk("idle_no_accept", {out_valid[0], in_ready[0], busy[0]}, 3'b010);

    // reset in the middle of RUN, then chain from IV with in_first=0
    @(negedge clk);
    in_block = EMPTY; in_first = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_reset_flags", {out_valid[0], in_ready[0], busy[0]}, 3'b010);
    chk("midrun_reset_digest", out_digest[0], IV);
    @(negedge clk); reset_n = 1'b1;
    lat = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid[0]) lat++;
    end
    chk("no_spurious_valid", lat, 0);
    send(0, ABC, 1'b0, dig, lat);
    chk("post_reset_chain_digest", dig, D_ABC);
    chk("post_reset_chain_latency", lat, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
